// File: rtl/seq_divide_pkg.sv
// Shared definitions for the sequential divider family: FSM encoding and
// counter sizing helper.
package seq_divide_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

    // Bit counter must hold the value n itself, hence n+1 codes.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_divide_step.sv
// One restoring-division step: shift the next numerator bit into the partial
// remainder and subtract the divisor if it fits.
module seq_divide_step #(
    parameter int unsigned DWidth = 4
) (
    input  logic [DWidth:0]   rem_i,
    input  logic              num_bit_i,
    input  logic [DWidth-1:0] divisor_i,
    output logic [DWidth:0]   rem_o,
    output logic              q_bit_o
);

    logic [DWidth+1:0] trial;

    always_comb begin
        trial   = {rem_i, num_bit_i};
        q_bit_o = (trial >= (DWidth + 2)'(divisor_i));
        // Partial remainder stays below the divisor, so the result fits DWidth+1 bits.
        rem_o   = q_bit_o ? (DWidth + 1)'(trial - (DWidth + 2)'(divisor_i))
                          : (DWidth + 1)'(trial);
    end

endmodule

// File: rtl/seq_divide.sv
// Multi-cycle restoring unsigned divider, one quotient bit per clock, with
// valid/ready handshakes and divide-by-zero flagging.
module seq_divide
    import seq_divide_pkg::*;
#(
    parameter int unsigned N_WIDTH = 8,
    parameter int unsigned D_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_WIDTH-1:0] numerator,
    input  logic [D_WIDTH-1:0] denominator,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_WIDTH-1:0] quotient,
    output logic [D_WIDTH-1:0] remain,
    output logic               div_by_zero,
    output logic               busy
);

    localparam int unsigned CntW = cnt_width(N_WIDTH);

    state_e             state_q, state_d;
    logic [D_WIDTH:0]   rem_q, rem_d;
    logic [N_WIDTH-1:0] shq_q, shq_d;
    logic [D_WIDTH-1:0] div_q, div_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [N_WIDTH-1:0] quot_q, quot_d;
    logic [D_WIDTH-1:0] rem_out_q, rem_out_d;
    logic               dbz_q, dbz_d;

    logic [D_WIDTH:0]   step_rem;
    logic               step_bit;
    logic [N_WIDTH-1:0] shq_next;

    seq_divide_step #(
        .DWidth(D_WIDTH)
    ) u_step (
        .rem_i    (rem_q),
        .num_bit_i(shq_q[N_WIDTH-1]),
        .divisor_i(div_q),
        .rem_o    (step_rem),
        .q_bit_o  (step_bit)
    );

    assign shq_next = {shq_q[N_WIDTH-2:0], step_bit};

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        shq_d     = shq_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        quot_d    = quot_q;
        rem_out_d = rem_out_q;
        dbz_d     = dbz_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (denominator == '0) begin
                        state_d   = StDone;
                        quot_d    = '1;
                        rem_out_d = '0;
                        dbz_d     = 1'b1;
                    end else begin
                        state_d = StCalc;
                        rem_d   = '0;
                        shq_d   = numerator;
                        div_d   = denominator;
                        cnt_d   = CntW'(N_WIDTH);
                    end
                end
            end
            StCalc: begin
                rem_d = step_rem;
                shq_d = shq_next;
                cnt_d = cnt_q - CntW'(1);
                // Last step: publish the result straight from the step outputs.
                if (cnt_q == CntW'(1)) begin
                    state_d   = StDone;
                    quot_d    = shq_next;
                    rem_out_d = step_rem[D_WIDTH-1:0];
                    dbz_d     = 1'b0;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            rem_q     <= '0;
            shq_q     <= '0;
            div_q     <= '0;
            cnt_q     <= '0;
            quot_q    <= '0;
            rem_out_q <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            shq_q     <= shq_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            quot_q    <= quot_d;
            rem_out_q <= rem_out_d;
            dbz_q     <= dbz_d;
        end
    end

    assign in_ready    = (state_q == StIdle);
    assign out_valid   = (state_q == StDone);
    assign busy        = (state_q != StIdle);
    assign quotient    = quot_q;
    assign remain      = rem_out_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divide.sv
// Self-checking bench: directed cases on an 8/4 divider, random sweep on a
// 16/8 divider, both against plain-arithmetic expectations.
module tb_seq_divide;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       in_valid_a = 1'b0, in_ready_a, out_valid_a, out_ready_a = 1'b1;
    logic [7:0] num_a = '0, quot_a;
    logic [3:0] den_a = '0, rem_a;
    logic       dbz_a, busy_a;

    logic        in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b1;
    logic [15:0] num_b = '0, quot_b;
    logic [7:0]  den_b = '0, rem_b;
    logic        dbz_b, busy_b;

    int checks = 0;
    int errors = 0;

    seq_divide #(.N_WIDTH(8), .D_WIDTH(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .numerator(num_a), .denominator(den_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .quotient(quot_a), .remain(rem_a),
        .div_by_zero(dbz_a), .busy(busy_a)
    );

    seq_divide #(.N_WIDTH(16), .D_WIDTH(8)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .numerator(num_b), .denominator(den_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .quotient(quot_b), .remain(rem_b),
        .div_by_zero(dbz_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request on the 8/4 divider and checks latency and result.
    // Latency counts edges after the accept edge until out_valid is seen;
    // a zero divisor goes straight to the result state on the accept edge.
    // Consumes the result only when out_ready_a is high.
    task automatic run_a(input int n, input int d, input string tag);
        int lat;
        int exp_q, exp_r, exp_lat;
        exp_q   = (d == 0) ? 255 : n / d;
        exp_r   = (d == 0) ? 0 : n % d;
        exp_lat = (d == 0) ? 0 : 8;
        check({tag, " in_ready before"}, 32'(in_ready_a), 1);
        in_valid_a = 1'b1;
        num_a = 8'(n);
        den_a = 4'(d);
        tick();
        in_valid_a = 1'b0;
        num_a = 8'($urandom);
        den_a = 4'($urandom);
        check({tag, " in_ready after accept"}, 32'(in_ready_a), 0);
        lat = 0;
        while (!out_valid_a && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " quotient"}, 32'(quot_a), 32'(exp_q));
        check({tag, " remain"}, 32'(rem_a), 32'(exp_r));
        check({tag, " div_by_zero"}, 32'(dbz_a), (d == 0) ? 1 : 0);
        if (out_ready_a) begin
            tick();
            check({tag, " out_valid after consume"}, 32'(out_valid_a), 0);
            check({tag, " in_ready after consume"}, 32'(in_ready_a), 1);
        end
    endtask

    task automatic run_b(input int n, input int d);
        int lat;
        int exp_q, exp_r, exp_lat;
        exp_q   = (d == 0) ? 65535 : n / d;
        exp_r   = (d == 0) ? 0 : n % d;
        exp_lat = (d == 0) ? 0 : 16;
        in_valid_b = 1'b1;
        num_b = 16'(n);
        den_b = 8'(d);
        tick();
        in_valid_b = 1'b0;
        num_b = 16'($urandom);
        den_b = 8'($urandom);
        lat = 0;
        while (!out_valid_b && lat < 60) begin
            tick();
            lat++;
        end
        check("rand latency", 32'(lat), 32'(exp_lat));
        check("rand quotient", 32'(quot_b), 32'(exp_q));
        check("rand remain", 32'(rem_b), 32'(exp_r));
        check("rand div_by_zero", 32'(dbz_b), (d == 0) ? 1 : 0);
        tick();
        check("rand in_ready after consume", 32'(in_ready_b), 1);
    endtask

    initial begin
        int n, d;
        repeat (3) tick();
        rst = 1'b0;
        check("reset in_ready", 32'(in_ready_a), 1);
        check("reset out_valid", 32'(out_valid_a), 0);
        check("reset quotient", 32'(quot_a), 0);
        check("reset remain", 32'(rem_a), 0);
        check("reset div_by_zero", 32'(dbz_a), 0);
        check("reset busy", 32'(busy_a), 0);

        run_a(19, 5, "19/5");
        run_a(255, 1, "255/1");
        run_a(7, 9, "7/9");
        run_a(0, 15, "0/15");
        run_a(200, 0, "200/0");
        run_a(19, 5, "19/5 after dbz");

        // Backpressure: result must hold and a second request must be ignored.
        out_ready_a = 1'b0;
        run_a(100, 7, "100/7");
        for (int i = 0; i < 5; i++) begin
            in_valid_a = 1'b1;
            num_a = 8'd9;
            den_a = 4'd3;
            tick();
            check("bp out_valid", 32'(out_valid_a), 1);
            check("bp in_ready", 32'(in_ready_a), 0);
            check("bp quotient", 32'(quot_a), 14);
            check("bp remain", 32'(rem_a), 2);
        end
        in_valid_a = 1'b0;
        out_ready_a = 1'b1;
        tick();
        check("bp out_valid after consume", 32'(out_valid_a), 0);
        check("bp in_ready after consume", 32'(in_ready_a), 1);
        check("bp busy after consume", 32'(busy_a), 0);

        // Reset three cycles into a calculation abandons it.
        in_valid_a = 1'b1;
        num_a = 8'd19;
        den_a = 4'd5;
        tick();
        in_valid_a = 1'b0;
        check("calc busy", 32'(busy_a), 1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst in_ready", 32'(in_ready_a), 1);
        check("midrst out_valid", 32'(out_valid_a), 0);
        check("midrst quotient", 32'(quot_a), 0);
        check("midrst remain", 32'(rem_a), 0);
        check("midrst div_by_zero", 32'(dbz_a), 0);
        check("midrst busy", 32'(busy_a), 0);
        repeat (10) tick();
        check("midrst no stale result", 32'(out_valid_a), 0);
        run_a(50, 6, "50/6");

        // Random sweep on the wide instance, with some zero divisors.
        for (int i = 0; i < 2000; i++) begin
            n = int'($urandom_range(0, 65535));
            d = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 255));
            if (i == 0) begin
                n = 65535;
                d = 1;
            end
            run_b(n, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
